// File: rtl/hps_pio_pkg.sv
// hps_pio_pkg: shared constants and register-map helpers for hps_pio_bank.
//   - CTRL / STATUS bit positions
//   - word-index helpers deriving CTRL, STATUS and ACTIVE locations from NUM_CH
package hps_pio_pkg;

  // CTRL register bits
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS register bits
  localparam int STAT_PENDING = 0;
  localparam int STAT_DONE    = 1;

  // Shadow registers occupy words 0..num_ch-1, followed by CTRL, STATUS,
  // then the ACTIVE readback block.
  function automatic int ctrl_idx(input int num_ch);
    return num_ch;
  endfunction

  function automatic int status_idx(input int num_ch);
    return num_ch + 1;
  endfunction

  function automatic int active_base(input int num_ch);
    return num_ch + 2;
  endfunction

endpackage

// File: rtl/hps_pio_bank_if.sv
// hps_pio_bank_if: Avalon-MM slave bus bundle for hps_pio_bank.
//   address    word address (ADDR_W bits)
//   chipselect slave select
//   write_n    active-low write strobe, qualified by chipselect
//   writedata  32-bit write data
//   readdata   32-bit combinational read data
// Modports: master (bridge / testbench side), slave (PIO side).
interface hps_pio_bank_if #(
  parameter int ADDR_W = 4
) ();

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/hps_pio_sync_edge.sv
// hps_pio_sync_edge: rising-edge detector for the frame-sync input.
//   clk      clock
//   reset_n  asynchronous active-low reset
//   sync_in  frame sync, already synchronous to clk
//   rise     combinational pulse: sync_in high while the registered copy is low
// The registered copy resets high so a sync line that is already high when
// reset is released is not mistaken for a fresh edge.
module hps_pio_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_in,
  output logic rise
);

  logic sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 1'b1;
    end else begin
      sync_q <= sync_in;
    end
  end

  assign rise = sync_in & ~sync_q;

endmodule

// File: rtl/hps_pio_bank.sv
// hps_pio_bank: multi-channel double-buffered Avalon-MM output PIO.
// Software fills per-channel SHADOW registers; a commit copies every SHADOW
// into its ACTIVE register at one edge, either immediately (AUTO=0) or on the
// next frame-sync rising edge (AUTO=1).
//   clk       clock
//   reset_n   asynchronous active-low reset
//   bus       Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   sync_in   frame sync, synchronous to clk
//   out_port  ACTIVE values, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   irq       registered DONE & IRQ_EN
module hps_pio_bank
  import hps_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    NUM_CH      = 4,
  parameter int                    ADDR_W      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  hps_pio_bank_if.slave                bus,
  input  logic                         sync_in,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_port,
  output logic                         irq
);

  localparam int CTRL_IDX   = ctrl_idx(NUM_CH);
  localparam int STATUS_IDX = status_idx(NUM_CH);
  localparam int ACT_BASE   = active_base(NUM_CH);

  logic [DATA_WIDTH-1:0] shadow_q [NUM_CH];
  logic [DATA_WIDTH-1:0] active_q [NUM_CH];
  logic                  auto_q;
  logic                  irq_en_q;
  logic                  pending_q;
  logic                  done_q;
  logic                  irq_q;

  logic [31:0]           addr32;
  logic                  wr;
  logic                  ctrl_wr;
  logic                  status_wr;
  logic                  new_auto;
  logic                  commit_req;
  logic                  sync_rise;
  logic                  commit;
  logic                  pending_next;
  logic                  done_next;
  logic [31:0]           rd;
  logic                  unused_wdata;

  hps_pio_sync_edge u_sync_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .sync_in (sync_in),
    .rise    (sync_rise)
  );

  // Upper writedata bits are architecturally ignored.
  assign unused_wdata = ^bus.writedata;

  assign addr32    = {{(32-ADDR_W){1'b0}}, bus.address};
  assign wr        = bus.chipselect & ~bus.write_n;
  assign ctrl_wr   = wr && (addr32 == 32'(CTRL_IDX));
  assign status_wr = wr && (addr32 == 32'(STATUS_IDX));

  // A CTRL write acts on the AUTO value it writes, not the old one.
  assign new_auto   = ctrl_wr ? bus.writedata[CTRL_AUTO] : auto_q;
  assign commit_req = ctrl_wr & bus.writedata[CTRL_COMMIT];

  // A request landing on a sync edge only arms PENDING; only a request that
  // was already pending before the edge fires. Dropping AUTO discards it.
  always_comb begin
    commit       = 1'b0;
    pending_next = 1'b0;
    if (new_auto) begin
      commit       = pending_q & sync_rise;
      pending_next = commit_req | (pending_q & ~sync_rise);
    end else begin
      commit       = commit_req;
      pending_next = 1'b0;
    end
  end

  // Setting DONE on a commit takes priority over a simultaneous W1C.
  always_comb begin
    done_next = done_q;
    if (status_wr && bus.writedata[STAT_DONE]) begin
      done_next = 1'b0;
    end
    if (commit) begin
      done_next = 1'b1;
    end
  end

  // Register file: shadow writes and atomic shadow->active copy.
  // ACTIVE copies the current SHADOW register, so a same-cycle shadow write
  // never leaks into the committed value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= RESET_VALUE;
        active_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr && (addr32 == 32'(i))) begin
          shadow_q[i] <= bus.writedata[DATA_WIDTH-1:0];
        end
        if (commit) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  // Control / status state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        auto_q   <= bus.writedata[CTRL_AUTO];
        irq_en_q <= bus.writedata[CTRL_IRQ_EN];
      end
      pending_q <= pending_next;
      done_q    <= done_next;
      irq_q     <= done_q & irq_en_q;
    end
  end

  // Combinational, zero-extended readback; unmapped words read 0.
  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr32 == 32'(i)) begin
        rd[DATA_WIDTH-1:0] = shadow_q[i];
      end
      if (addr32 == 32'(ACT_BASE + i)) begin
        rd[DATA_WIDTH-1:0] = active_q[i];
      end
    end
    if (addr32 == 32'(CTRL_IDX)) begin
      rd[CTRL_AUTO]   = auto_q;
      rd[CTRL_IRQ_EN] = irq_en_q;
    end
    if (addr32 == 32'(STATUS_IDX)) begin
      rd[STAT_PENDING] = pending_q;
      rd[STAT_DONE]    = done_q;
    end
  end

  assign bus.readdata = rd;
  assign irq          = irq_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign out_port[g*DATA_WIDTH +: DATA_WIDTH] = active_q[g];
  end

endmodule

// File: tb/tb_hps_pio_bank.sv
// tb_hps_pio_bank: directed self-checking bench for hps_pio_bank.
// DUT A: DATA_WIDTH=16, NUM_CH=4, ADDR_W=4, RESET_VALUE=16'h00FF
//   map: SHADOW 0..3, CTRL 4, STATUS 5, ACTIVE 6..9
// DUT B: DATA_WIDTH=8, NUM_CH=8, ADDR_W=5, RESET_VALUE=0
//   map: SHADOW 0..7, CTRL 8, STATUS 9, ACTIVE 10..17
module tb_hps_pio_bank;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sync_a;
  logic        sync_b;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic        irq_a;
  logic        irq_b;
  logic [31:0] rdv;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hps_pio_bank_if #(.ADDR_W(4)) bus_a ();
  hps_pio_bank_if #(.ADDR_W(5)) bus_b ();

  hps_pio_bank #(
    .DATA_WIDTH  (16),
    .NUM_CH      (4),
    .ADDR_W      (4),
    .RESET_VALUE (16'h00FF)
  ) dut_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_a.slave),
    .sync_in  (sync_a),
    .out_port (out_a),
    .irq      (irq_a)
  );

  hps_pio_bank #(
    .DATA_WIDTH  (8),
    .NUM_CH      (8),
    .ADDR_W      (5),
    .RESET_VALUE (8'h00)
  ) dut_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_b.slave),
    .sync_in  (sync_b),
    .out_port (out_b),
    .irq      (irq_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Writes are driven at negedge and return 1 ns after the sampling edge.
  task automatic wr_a(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_a.address = a; bus_a.writedata = d;
    bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
    @(posedge clk); #1;
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
  endtask

  task automatic rd_a(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_a.address = a; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b1;
    #1 d = bus_a.readdata;
    bus_a.chipselect = 1'b0;
  endtask

  task automatic wr_b(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_b.address = a; bus_b.writedata = d;
    bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
    @(posedge clk); #1;
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
  endtask

  task automatic rd_b(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_b.address = a; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b1;
    #1 d = bus_b.readdata;
    bus_b.chipselect = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    sync_a  = 1'b1;
    sync_b  = 1'b0;
    bus_a.address = '0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    bus_b.address = '0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state, sync_a already high at release
    chk("rst_out_a", out_a, 64'h00FF_00FF_00FF_00FF);
    chk("rst_irq_a", {63'd0, irq_a}, 64'd0);
    rd_a(4'd5, rdv); chk("rst_status_a", {32'd0, rdv}, 64'd0);
    rd_a(4'd4, rdv); chk("rst_ctrl_a", {32'd0, rdv}, 64'd0);
    chk("rst_out_b", out_b, 64'd0);

    @(negedge clk) sync_a = 1'b0;

    // Manual commit (AUTO=0)
    wr_a(4'd0, 32'h0000_ABCD);
    wr_a(4'd3, 32'h0000_1234);
    rd_a(4'd6, rdv); chk("pre_commit_active0", {32'd0, rdv}, 64'h0000_00FF);
    rd_a(4'd0, rdv); chk("shadow0_read", {32'd0, rdv}, 64'h0000_ABCD);
    chk("pre_commit_out", out_a, 64'h00FF_00FF_00FF_00FF);
    wr_a(4'd4, 32'h0000_0001);
    chk("manual_commit_out", out_a, 64'h1234_00FF_00FF_ABCD);
    rd_a(4'd6, rdv); chk("post_commit_active0", {32'd0, rdv}, 64'h0000_ABCD);
    rd_a(4'd9, rdv); chk("post_commit_active3", {32'd0, rdv}, 64'h0000_1234);
    rd_a(4'd5, rdv); chk("manual_status", {32'd0, rdv}, 64'd2);
    rd_a(4'd4, rdv); chk("ctrl_commit_reads0", {32'd0, rdv}, 64'd0);
    rd_a(4'd12, rdv); chk("unmapped_read_a", {32'd0, rdv}, 64'd0);

    // Auto commit with interrupt
    wr_a(4'd5, 32'h0000_0002);
    wr_a(4'd1, 32'h0000_5A5A);
    wr_a(4'd4, 32'h0000_0007);
    rd_a(4'd5, rdv); chk("auto_pending", {32'd0, rdv}, 64'd1);
    chk("auto_out_held", out_a, 64'h1234_00FF_00FF_ABCD);
    rd_a(4'd4, rdv); chk("ctrl_readback", {32'd0, rdv}, 64'd6);
    @(negedge clk) sync_a = 1'b1;
    @(posedge clk); #1;
    chk("auto_commit_out", out_a, 64'h1234_00FF_5A5A_ABCD);
    rd_a(4'd5, rdv); chk("auto_status_done", {32'd0, rdv}, 64'd2);
    chk("irq_not_yet", {63'd0, irq_a}, 64'd0);
    @(posedge clk); #1;
    chk("irq_asserted", {63'd0, irq_a}, 64'd1);
    @(negedge clk) sync_a = 1'b0;
    wr_a(4'd5, 32'h0000_0002);
    @(posedge clk); #1;
    chk("irq_cleared", {63'd0, irq_a}, 64'd0);

    // Commit request coinciding with a sync rising edge
    wr_a(4'd2, 32'h0000_7777);
    @(negedge clk);
    sync_a = 1'b1;
    bus_a.address = 4'd4; bus_a.writedata = 32'h0000_0007;
    bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
    @(posedge clk); #1;
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
    chk("same_edge_no_commit", out_a, 64'h1234_00FF_5A5A_ABCD);
    rd_a(4'd5, rdv); chk("same_edge_pending", {32'd0, rdv}, 64'd1);
    sync_a = 1'b0;
    @(negedge clk) sync_a = 1'b1;
    @(posedge clk); #1;
    chk("next_edge_commit", out_a, 64'h1234_7777_5A5A_ABCD);
    @(negedge clk) sync_a = 1'b0;

    // AUTO cleared while pending: request discarded
    wr_a(4'd5, 32'h0000_0002);
    wr_a(4'd0, 32'h0000_1111);
    wr_a(4'd4, 32'h0000_0007);
    wr_a(4'd4, 32'h0000_0003);
    rd_a(4'd5, rdv); chk("repeat_commit_pending", {32'd0, rdv}, 64'd1);
    wr_a(4'd4, 32'h0000_0000);
    rd_a(4'd5, rdv); chk("cancel_status", {32'd0, rdv}, 64'd0);
    @(negedge clk) sync_a = 1'b1;
    @(posedge clk); #1;
    @(negedge clk) sync_a = 1'b0;
    @(posedge clk); #1;
    chk("cancel_out_held", out_a, 64'h1234_7777_5A5A_ABCD);
    rd_a(4'd6, rdv); chk("cancel_active0", {32'd0, rdv}, 64'h0000_ABCD);

    // Second configuration: 8 channels x 8 bits
    wr_b(5'd3, 32'hFFFF_FF3C);
    rd_b(5'd3, rdv); chk("b_shadow3", {32'd0, rdv}, 64'h0000_003C);
    wr_b(5'd8, 32'h0000_0001);
    chk("b_commit_out", out_b, 64'h0000_0000_3C00_0000);
    rd_b(5'd13, rdv); chk("b_active3", {32'd0, rdv}, 64'h0000_003C);
    rd_b(5'd20, rdv); chk("b_unmapped", {32'd0, rdv}, 64'd0);
    wr_b(5'd9, 32'h0000_0002);
    rd_b(5'd9, rdv); chk("b_done_cleared", {32'd0, rdv}, 64'd0);
    wr_b(5'd8, 32'h0000_0003);
    rd_b(5'd9, rdv); chk("b_pending", {32'd0, rdv}, 64'd1);
    // DONE W1C in the same cycle as the sync commit: set wins
    @(negedge clk);
    sync_b = 1'b1;
    bus_b.address = 5'd9; bus_b.writedata = 32'h0000_0002;
    bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
    @(posedge clk); #1;
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
    rd_b(5'd9, rdv); chk("b_done_set_wins", {32'd0, rdv}, 64'd2);
    chk("b_irq_disabled", {63'd0, irq_b}, 64'd0);

    // Reset mid-operation clears a pending request
    wr_a(4'd5, 32'h0000_0002);
    wr_a(4'd4, 32'h0000_0003);
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    rd_a(4'd5, rdv); chk("reset_clears_pending", {32'd0, rdv}, 64'd0);
    chk("reset_out_a", out_a, 64'h00FF_00FF_00FF_00FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hps_pio_bank.md
# hps_pio_bank

Parametrised multi-channel, double-buffered Avalon-MM output PIO, the successor to the single 16-bit HPS VGA data port. Software writes per-channel shadow registers. All channels then update their outputs atomically, either on an explicit commit or on the next rising edge of a frame-sync input. This gives tear-free updates of VGA control/data words from the HPS lightweight bridge. A completion flag with optional interrupt reports each commit.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per channel, 1..32
- NUM_CH, 4, number of output channels, 1..8
- ADDR_W, 4, word-address width; 2*NUM_CH+2 <= 2**ADDR_W required
- RESET_VALUE, 0, reset value of every shadow and active register (DATA_WIDTH bits)

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- address  in  ADDR_W  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data; bits above DATA_WIDTH ignored
- readdata  out  32  read data, zero-extended, zero wait/zero latency
- sync_in  in  1  frame sync (e.g. vsync), synchronous to clk
- out_port  out  NUM_CH*DATA_WIDTH  active values, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- irq  out  1  level interrupt

## Operation
Register map (word index):
- 0..NUM_CH-1: SHADOW[i], RW.
- NUM_CH: CTRL.
  - bit0 COMMIT: write-1 action, reads 0.
  - bit1 AUTO: RW.
  - bit2 IRQ_EN: RW.
- NUM_CH+1: STATUS.
  - bit0 PENDING: RO.
  - bit1 DONE: write-1-to-clear.
- NUM_CH+2..2*NUM_CH+1: ACTIVE[i], RO readback.
- Unmapped addresses read 0; writes to them are ignored.

Write and read rules:
- A write occurs when chipselect=1 and write_n=0.
- Reads are combinational from the current register state.

Commit behaviour:
- Commit means all ACTIVE[i] <= SHADOW[i] at the same edge. DONE is set at that edge.
- AUTO=0: a CTRL write with COMMIT=1 commits at the edge that samples the write.
- AUTO=1: a CTRL write with COMMIT=1 sets PENDING. A sync rising edge with PENDING=1 commits and clears PENDING.
- sync rising edge detection: sync_in=1 and sync_q=0, where sync_q is sync_in registered.
- irq = DONE & IRQ_EN, registered.

Boundary conditions:
- A CTRL write with COMMIT=1 that also changes AUTO acts on the new AUTO value.
- A commit request in the same cycle as a sync rising edge only sets PENDING. The commit waits for the next rising edge.
- Repeated COMMIT while PENDING=1: no effect beyond keeping PENDING=1.
- AUTO cleared while PENDING=1: PENDING is cleared, no commit occurs.
- SHADOW is only modified by its own write, so a commit always copies the pre-write value.
- DONE W1C in the same cycle as a commit: set wins.

## Timing
Reset values:
- SHADOW and ACTIVE = RESET_VALUE, so out_port = RESET_VALUE replicated.
- CTRL = 0, PENDING = 0, DONE = 0, irq = 0.
- sync_q resets to 1, so sync_in already high at reset release produces no edge.

Latencies:
- Manual commit: out_port changes at the write edge; readdata of ACTIVE reflects it the next cycle.
- Auto commit: out_port changes at the edge where sync_in is first sampled high after being low; DONE is set at the same edge.
- irq asserts one cycle after DONE and IRQ_EN are both 1.
- irq deasserts one cycle after DONE is cleared or IRQ_EN is cleared.

Reset mid-operation clears PENDING; no commit occurs.

## Structure
- Package hps_pio_pkg holds:
  - CTRL bit positions (COMMIT=0, AUTO=1, IRQ_EN=2).
  - STATUS bit positions (PENDING=0, DONE=1).
  - Functions returning CTRL, STATUS and ACTIVE base indices from NUM_CH.
- One sub-module: hps_pio_sync_edge, the registered rising-edge detector with reset value 1. Register file and commit logic stay in the top module.

## Test plan
- Reset with sync_in=1, RESET_VALUE=16'h00FF, then release: out_port all channels 16'h00FF, no DONE, irq=0.
- AUTO=0: write SHADOW[0]=16'hABCD, SHADOW[3]=16'h1234, CTRL=1: out_port ch0/ch3 update at that edge. Before the commit, ACTIVE readback returns the old value. STATUS reads 2.
- AUTO=1, IRQ_EN=1: write SHADOW[1]=16'h5A5A, CTRL=7: PENDING=1 and out_port unchanged. Pulse sync_in: ch1=16'h5A5A at the rising edge, PENDING=0, irq=1 next cycle. Write STATUS=2: irq=0.
- Commit request in the same cycle as a sync rising edge: no update on that edge; update on the next sync rising edge.
- AUTO=1 with PENDING=1, then write CTRL=0: PENDING=0 and a later sync edge leaves out_port unchanged. Repeat with DATA_WIDTH=8, NUM_CH=8, ADDR_W=5: writedata=32'hFFFF_FF3C yields channel value 8'h3C and readdata 32'h0000_003C.
